// File: rtl/store_buffer_ctrl_pkg.sv
// Shared types for the post-commit store buffer: the committed-store record,
// the geometry constants, and the word-granular address compare.
package store_buffer_ctrl_pkg;

  localparam int ADDR_WIDTH         = 32;
  localparam int DATA_WIDTH         = 32;
  localparam int STRB_WIDTH         = DATA_WIDTH / 8;
  localparam int WORD_OFF_W         = $clog2(STRB_WIDTH);
  localparam int STORE_BUFFER_DEPTH = 4;

  typedef struct packed {
    logic                  valid;
    logic [STRB_WIDTH-1:0] wstrb;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } store_req_t;

  // Two byte addresses hit the same word when they differ only in the byte offset.
  function automatic logic word_match(input logic [ADDR_WIDTH-1:0] a,
                                      input logic [ADDR_WIDTH-1:0] b);
    return ((a ^ b) >> WORD_OFF_W) == '0;
  endfunction

endpackage

// File: rtl/store_buffer_ctrl_if.sv
// Commit-side, DCache-side and load-query signals of the store buffer,
// bundled with a slave view for the buffer and a master view for its environment.
interface store_buffer_ctrl_if
  #(parameter int SB_DEPTH = store_buffer_ctrl_pkg::STORE_BUFFER_DEPTH);
  import store_buffer_ctrl_pkg::*;

  store_req_t                  enq_req_i;
  logic                        enq_ready_o;
  store_req_t                  dcache_req_o;
  logic                        dcache_ready_i;
  logic                        load_query_valid_i;
  logic [ADDR_WIDTH-1:0]       load_query_addr_i;
  logic                        load_conflict_o;
  logic                        drain_req_i;
  logic                        empty_o;
  logic [$clog2(SB_DEPTH):0]   count_o;

  modport slave (
    input  enq_req_i, dcache_ready_i, load_query_valid_i, load_query_addr_i, drain_req_i,
    output enq_ready_o, dcache_req_o, load_conflict_o, empty_o, count_o
  );

  modport master (
    output enq_req_i, dcache_ready_i, load_query_valid_i, load_query_addr_i, drain_req_i,
    input  enq_ready_o, dcache_req_o, load_conflict_o, empty_o, count_o
  );

endinterface

// File: rtl/store_buffer_match.sv
// Combinational vector of word comparators: each candidate address against one query.
module store_buffer_match
  import store_buffer_ctrl_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [ADDR_WIDTH-1:0]        query,
  input  logic [N-1:0][ADDR_WIDTH-1:0] cand,
  output logic [N-1:0]                 hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) hit[i] = word_match(cand[i], query);
  end

endmodule

// File: rtl/store_buffer_ctrl.sv
// In-order post-commit store buffer with youngest-entry byte combining,
// one-per-handshake drain to the DCache and word-granular load conflict detection.
module store_buffer_ctrl
  import store_buffer_ctrl_pkg::*;
#(
  parameter int SB_DEPTH = STORE_BUFFER_DEPTH
) (
  input logic               clk,
  input logic               rst,
  store_buffer_ctrl_if.slave sb
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  store_req_t              mem [SB_DEPTH];
  logic [SB_DEPTH-1:0]     ent_vld;
  logic [PTR_W:0]          head;
  logic [PTR_W:0]          tail;

  logic [PTR_W-1:0]        head_idx;
  logic [PTR_W-1:0]        tail_idx;
  logic [PTR_W-1:0]        yng_idx;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    empty;

  logic [0:0][ADDR_WIDTH-1:0]        yng_addr;
  logic [0:0]                        yng_hit;
  logic [SB_DEPTH:0][ADDR_WIDTH-1:0] cand_addr;
  logic [SB_DEPTH:0]                 query_hit;

  logic                    merge_hit;
  logic                    accept;
  logic                    has_bytes;
  logic                    push;
  logic                    merge;
  logic                    pop;

  function automatic store_req_t merge_bytes(input store_req_t            old_e,
                                             input logic [STRB_WIDTH-1:0] strb,
                                             input logic [DATA_WIDTH-1:0] data);
    store_req_t m;
    m = old_e;
    for (int b = 0; b < STRB_WIDTH; b++)
      if (strb[b]) m.wdata[8*b +: 8] = data[8*b +: 8];
    m.wstrb = old_e.wstrb | strb;
    return m;
  endfunction

  assign head_idx = head[PTR_W-1:0];
  assign tail_idx = tail[PTR_W-1:0];
  assign yng_idx  = tail_idx - PTR_W'(1);
  assign count    = tail - head;
  assign empty    = (head == tail);
  assign full     = (head[PTR_W] != tail[PTR_W]) && (head_idx == tail_idx);

  // The head may already be on the DCache port, so only a non-head youngest entry merges.
  assign yng_addr[0] = mem[yng_idx].waddr;

  store_buffer_match #(.N(1)) u_merge_match (
    .query (sb.enq_req_i.waddr),
    .cand  (yng_addr),
    .hit   (yng_hit)
  );

  always_comb begin
    cand_addr = '0;
    for (int i = 0; i < SB_DEPTH; i++) cand_addr[i] = mem[i].waddr;
    cand_addr[SB_DEPTH] = sb.enq_req_i.waddr;
  end

  store_buffer_match #(.N(SB_DEPTH + 1)) u_load_match (
    .query (sb.load_query_addr_i),
    .cand  (cand_addr),
    .hit   (query_hit)
  );

  assign merge_hit = sb.enq_req_i.valid && (count >= CNT_W'(2)) && yng_hit[0];
  assign sb.enq_ready_o = !sb.drain_req_i && (!full || merge_hit);

  assign accept    = sb.enq_req_i.valid && sb.enq_ready_o;
  assign has_bytes = |sb.enq_req_i.wstrb;
  assign push      = accept && has_bytes && !merge_hit;
  assign merge     = accept && has_bytes && merge_hit;
  assign pop       = !empty && sb.dcache_ready_i;

  assign sb.load_conflict_o = sb.load_query_valid_i &&
                              ((|(query_hit[SB_DEPTH-1:0] & ent_vld)) ||
                               (sb.enq_req_i.valid && has_bytes && query_hit[SB_DEPTH]));

  always_comb begin
    sb.dcache_req_o       = mem[head_idx];
    sb.dcache_req_o.valid = !empty;
  end

  assign sb.empty_o = empty;
  assign sb.count_o = count;

  // Pointer/valid update: enqueue and pop never touch the same slot in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        head              <= head + CNT_W'(1);
        ent_vld[head_idx] <= 1'b0;
      end
      if (push) begin
        tail              <= tail + CNT_W'(1);
        ent_vld[tail_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[tail_idx] <= sb.enq_req_i;
    else if (merge)
      mem[yng_idx]  <= merge_bytes(mem[yng_idx], sb.enq_req_i.wstrb, sb.enq_req_i.wdata);
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed bench for store_buffer_ctrl: a vector table for single-cycle behaviour
// plus hand-written sequences for back-pressure, wrap-around, drain and async reset.
module tb_store_buffer_ctrl;
  import store_buffer_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  store_buffer_ctrl_if #(.SB_DEPTH(4)) sb ();

  store_buffer_ctrl #(.SB_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb.slave)
  );

  typedef struct {
    logic        ev;
    logic [3:0]  es;
    logic [31:0] ea;
    logic [31:0] ed;
    logic        rdy;
    logic        qv;
    logic [31:0] qa;
    logic        drn;
    logic        x_rdy;
    logic        x_conf;
    logic        x_dv;
    logic [31:0] x_da;
    logic [31:0] x_dd;
    logic [3:0]  x_ds;
    logic [2:0]  x_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } exp_t;

  vec_t vq[$];
  exp_t sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic v, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d);
    sb.enq_req_i.valid = v;
    sb.enq_req_i.waddr = a;
    sb.enq_req_i.wstrb = s;
    sb.enq_req_i.wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   sent;
    logic hs;
    logic acc;
    exp_t e;

    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    sb.dcache_ready_i     = 1'b0;
    sb.load_query_valid_i = 1'b0;
    sb.load_query_addr_i  = 32'h0;
    sb.drain_req_i        = 1'b0;
    #1;
    check("rst_count", 64'(sb.count_o), 64'd0);
    check("rst_empty", 64'(sb.empty_o), 64'd1);
    check("rst_dvalid", 64'(sb.dcache_req_o.valid), 64'd0);
    check("rst_enq_ready", 64'(sb.enq_ready_o), 64'd1);
    check("rst_conflict", 64'(sb.load_conflict_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ev es ea ed rdy qv qa drn | x_rdy x_conf x_dv x_da x_dd x_ds x_cnt
    vq.push_back('{1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 3'd0});
    vq.push_back('{1'b1, 4'hF, 32'h1000, 32'hAABBCCDD, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    32'h0,        4'h0, 3'd1});
    vq.push_back('{1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 32'hAABBCCDD, 4'hF, 3'd0});
    vq.push_back('{1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 3'd0});
    vq.push_back('{1'b1, 4'h1, 32'h2000, 32'h11,       1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 3'd1});
    vq.push_back('{1'b1, 4'h3, 32'h3000, 32'h2222,     1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h11,       4'h1, 3'd2});
    vq.push_back('{1'b1, 4'hC, 32'h3002, 32'h33330000, 1'b0, 1'b1, 32'h2003, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 32'h11,       4'h1, 3'd2});
    vq.push_back('{1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h4000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h11,       4'h1, 3'd1});
    vq.push_back('{1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h3000, 32'h33332222, 4'hF, 3'd0});
    vq.push_back('{1'b1, 4'hF, 32'h4004, 32'h12345678, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 3'd1});
    vq.push_back('{1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h4006, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4004, 32'h12345678, 4'hF, 3'd1});
    vq.push_back('{1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h4008, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4004, 32'h12345678, 4'hF, 3'd1});
    vq.push_back('{1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h4004, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4004, 32'h12345678, 4'hF, 3'd0});
    vq.push_back('{1'b1, 4'hF, 32'h5000, 32'hCAFE,     1'b0, 1'b1, 32'h5001, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    32'h0,        4'h0, 3'd1});
    vq.push_back('{1'b1, 4'h0, 32'h6000, 32'h0,        1'b0, 1'b1, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h5000, 32'hCAFE,     4'hF, 3'd1});
    vq.push_back('{1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h5000, 32'hCAFE,     4'hF, 3'd0});
    vq.push_back('{1'b1, 4'hF, 32'h7000, 32'h1,        1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 3'd0});

    foreach (vq[i]) begin
      drive_enq(vq[i].ev, vq[i].ea, vq[i].es, vq[i].ed);
      sb.dcache_ready_i     = vq[i].rdy;
      sb.load_query_valid_i = vq[i].qv;
      sb.load_query_addr_i  = vq[i].qa;
      sb.drain_req_i        = vq[i].drn;
      #1;
      check($sformatf("v%0d_enq_ready", i), 64'(sb.enq_ready_o), 64'(vq[i].x_rdy));
      check($sformatf("v%0d_conflict", i), 64'(sb.load_conflict_o), 64'(vq[i].x_conf));
      check($sformatf("v%0d_dvalid", i), 64'(sb.dcache_req_o.valid), 64'(vq[i].x_dv));
      if (vq[i].x_dv) begin
        check($sformatf("v%0d_daddr", i), 64'(sb.dcache_req_o.waddr), 64'(vq[i].x_da));
        check($sformatf("v%0d_ddata", i), 64'(sb.dcache_req_o.wdata), 64'(vq[i].x_dd));
        check($sformatf("v%0d_dstrb", i), 64'(sb.dcache_req_o.wstrb), 64'(vq[i].x_ds));
      end
      step();
      check($sformatf("v%0d_count", i), 64'(sb.count_o), 64'(vq[i].x_cnt));
      check($sformatf("v%0d_empty", i), 64'(sb.empty_o), 64'(vq[i].x_cnt == 3'd0));
    end
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    sb.drain_req_i        = 1'b0;
    sb.load_query_valid_i = 1'b0;

    // Fill to full under back-pressure, then merge into the tail word.
    sb.dcache_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_enq(1'b1, 32'h100 + 32'(4*k), 4'h3, 32'h1000 + 32'(k));
      #1;
      check($sformatf("fill%0d_ready", k), 64'(sb.enq_ready_o), 64'd1);
      step();
    end
    check("full_count", 64'(sb.count_o), 64'd4);
    drive_enq(1'b1, 32'h110, 4'hF, 32'h55);
    #1;
    check("full_ready_distinct", 64'(sb.enq_ready_o), 64'd0);
    drive_enq(1'b1, 32'h10E, 4'hC, 32'hBEEF0000);
    #1;
    check("full_ready_merge", 64'(sb.enq_ready_o), 64'd1);
    step();
    check("full_count_after_merge", 64'(sb.count_o), 64'd4);
    sbq.push_back('{32'h100, 32'h1000, 4'h3});
    sbq.push_back('{32'h104, 32'h1001, 4'h3});
    sbq.push_back('{32'h108, 32'h1002, 4'h3});
    sbq.push_back('{32'h10C, 32'hBEEF1003, 4'hF});

    // Release back-pressure and push six more stores through the wrapping pointers.
    sent = 0;
    sb.dcache_ready_i = 1'b1;
    for (int cyc = 0; cyc < 60 && (sbq.size() > 0 || sent < 6); cyc++) begin
      drive_enq(sent < 6, 32'h200 + 32'(4*sent), 4'hF, 32'hA0 + 32'(sent));
      #1;
      hs  = sb.dcache_req_o.valid;
      acc = sb.enq_req_i.valid && sb.enq_ready_o;
      if (hs) begin
        if (sbq.size() == 0) begin
          check("wrap_unexpected_pop", 64'(sb.dcache_req_o.waddr), 64'hFFFF_FFFF);
        end else begin
          check($sformatf("wrap_addr_c%0d", cyc), 64'(sb.dcache_req_o.waddr), 64'(sbq[0].a));
          check($sformatf("wrap_data_c%0d", cyc), 64'(sb.dcache_req_o.wdata), 64'(sbq[0].d));
          check($sformatf("wrap_strb_c%0d", cyc), 64'(sb.dcache_req_o.wstrb), 64'(sbq[0].s));
        end
      end
      step();
      if (hs && sbq.size() > 0) void'(sbq.pop_front());
      if (acc) begin
        e.a = 32'h200 + 32'(4*sent);
        e.d = 32'hA0 + 32'(sent);
        e.s = 4'hF;
        sbq.push_back(e);
        sent++;
      end
    end
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    check("wrap_all_sent", 64'(sent), 64'd6);
    check("wrap_all_drained", 64'(sbq.size()), 64'd0);
    check("wrap_empty", 64'(sb.empty_o), 64'd1);

    // Drain request blocks enqueue while the buffer empties.
    sb.dcache_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_enq(1'b1, 32'h300 + 32'(4*k), 4'hF, 32'h30 + 32'(k));
      step();
    end
    check("drain_count3", 64'(sb.count_o), 64'd3);
    drive_enq(1'b1, 32'h30C, 4'hF, 32'h33);
    sb.drain_req_i = 1'b1;
    #1;
    check("drain_enq_ready", 64'(sb.enq_ready_o), 64'd0);
    sb.dcache_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("drain%0d_dvalid", k), 64'(sb.dcache_req_o.valid), 64'd1);
      check($sformatf("drain%0d_daddr", k), 64'(sb.dcache_req_o.waddr), 64'h300 + 64'(4*k));
      step();
    end
    check("drain_empty", 64'(sb.empty_o), 64'd1);
    check("drain_count0", 64'(sb.count_o), 64'd0);
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    sb.drain_req_i = 1'b0;

    // Asynchronous reset mid-cycle with two entries pending.
    sb.dcache_ready_i = 1'b0;
    drive_enq(1'b1, 32'h400, 4'hF, 32'h40);
    step();
    drive_enq(1'b1, 32'h404, 4'hF, 32'h41);
    step();
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    check("pre_rst_count", 64'(sb.count_o), 64'd2);
    check("pre_rst_dvalid", 64'(sb.dcache_req_o.valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dvalid", 64'(sb.dcache_req_o.valid), 64'd0);
    check("async_rst_count", 64'(sb.count_o), 64'd0);
    check("async_rst_empty", 64'(sb.empty_o), 64'd1);
    check("async_rst_enq_ready", 64'(sb.enq_ready_o), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    check("post_rst_count", 64'(sb.count_o), 64'd0);
    check("post_rst_dvalid", 64'(sb.dcache_req_o.valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/store_buffer_ctrl.md
Name: store_buffer_ctrl

Overview:
Post-commit store buffer and drain scheduler between the WB/commit stage and the DCache write port. Committed stores (store_req_t) are queued in order, same-word stores are combined into the youngest non-head entry, and entries drain one per handshake to the DCache. A load-conflict check stalls younger loads that overlap a pending store. A drain request empties the buffer before barriers, cacop and uncached accesses.

Parameters:
SB_DEPTH, 4, number of entries (power of two, ≥2)
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, store data width; word = DATA_WIDTH/8 bytes

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
enq_req_i  in  store_req_t  committed store from WB; valid/wstrb/waddr/wdata
enq_ready_o  out  1  store accepted this cycle when enq_req_i.valid && enq_ready_o
dcache_req_o  out  store_req_t  head entry presented to DCache; valid = buffer non-empty
dcache_ready_i  in  1  DCache accepts dcache_req_o this cycle
load_query_valid_i  in  1  MEM1 load address valid
load_query_addr_i  in  ADDR_WIDTH  MEM1 load byte address
load_conflict_o  out  1  load must stall: word overlaps a pending or enqueuing store
drain_req_i  in  1  barrier/cacop/uncached access wants buffer emptied
empty_o  out  1  no valid entries
count_o  out  $clog2(SB_DEPTH)+1  number of valid entries

Behaviour:
- Storage: circular array of SB_DEPTH store_req_t entries; head/tail pointers carry an extra wrap bit. full = ptrs equal except wrap bit; empty = ptrs fully equal.
- Reset (async, immediate): head=tail=0, all entry valid=0, count_o=0, empty_o=1, dcache_req_o.valid=0, enq_ready_o=1, load_conflict_o=0. Reset mid-drain drops dcache_req_o.valid in the same cycle; buffered stores are discarded.
- Word match = equality of addr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)].
- Merge: merge_hit = enq valid && count ≥ 2 && youngest entry (tail-1) word-matches enq. The head entry is never merged, because it may be visible on dcache_req_o. On merge: the youngest entry's bytes with enq wstrb set take enq wdata bytes; its wstrb |= enq wstrb; tail unchanged.
- enq_ready_o = !drain_req_i && (!full || merge_hit). Purely from current state and inputs; independent of dcache_ready_i. There is no same-cycle pop→enqueue bypass when full.
- Enqueue without merge writes the entry at tail, then tail++. Enqueue with wstrb==0 is accepted and discarded (no entry, no count change).
- Drain: dcache_req_o is the head entry directly from registers, valid = !empty. On valid && dcache_ready_i, head++ and the entry is invalidated. The payload must stay stable while valid && !ready.
- Latency: a store accepted in cycle N appears on dcache_req_o at N+1 at the earliest (when the buffer was empty).
- Simultaneous enqueue + pop: both take effect; count_o unchanged; wrap-around handled by pointer arithmetic mod 2·SB_DEPTH.
- count_o and empty_o are registered and reflect the post-update state. Order is strictly FIFO except byte combining.
- load_conflict_o = load_query_valid_i && (any valid entry word-matches the query, including the head being popped this cycle || (enq_req_i.valid && enq wstrb≠0 && word-match)). Byte-granular overlap is not refined; a word match is a conflict.
- drain_req_i blocks enqueue only; draining continues. The requester waits for empty_o=1.

Decomposition:
- store_req_t stays in core_types. SB_DEPTH is added to core_config as STORE_BUFFER_DEPTH.
- One sub-module: store_buffer_match, a combinational per-entry word comparator vector. It is shared by merge detection (tail-1 vs enq) and load-conflict detection (all entries + enq vs query).

Test Plan:
- Basic: enqueue {addr 0x1000, wstrb 4'b1111, data 0xAABBCCDD}, dcache_ready_i=1 → dcache_req_o.valid next cycle with same payload; empty_o=1 the cycle after the handshake; count_o sequence 0,1,0.
- Merge: dcache_ready_i=0; enqueue 0x2000/4'b0001/0x11, 0x3000/4'b0011/0x2222, then 0x3002/4'b1100/0x33330000 → count_o=2; second entry wstrb 4'b1111, data 0x33332222; head untouched.
- Full/back-pressure: dcache_ready_i=0; fill 4 distinct words → enq_ready_o=0 for a fifth distinct word. A store to the tail's word is still accepted and merged. Raise ready → FIFO order preserved, including across pointer wrap after 6 more stores.
- Load conflict: pending 0x4004; query 0x4006 → conflict=1; query 0x4008 → 0. An empty buffer with enq_req_i of 0x5000 and query 0x5001 in the same cycle → conflict=1.
- Drain: 3 entries, assert drain_req_i → enq_ready_o=0 immediately; entries drain; empty_o=1 after the third handshake.
- Reset: async rst asserted mid-cycle with 2 entries and dcache_req_o.valid=1 → valid, count_o drop to 0 without a clock edge; enq_ready_o=1.
